// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port, synchronous-read memory between instruction fetch
// and the load/store unit. Data requests win, except when fetch has been starved.
module imem_dmem_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_valid,
    output logic              if_ready,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_rdata,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wbe,
    output logic              d_resp_valid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       starve;
    logic       if_fire;
    logic       d_fire;

    // Once fetch has been denied MAX_WAIT times in a row it overrides data priority.
    assign starve   = (wait_cnt == WAIT_LIMIT);
    assign d_ready  = ~rst & d_valid & ~(if_valid & starve);
    assign if_ready = ~rst & if_valid & (~d_valid | starve);

    assign if_fire  = if_valid & if_ready;
    assign d_fire   = d_valid & d_ready;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the block leaves a value unassigned and a latch can never be inferred.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'b0000;
        mem_addr = '0;
        mem_din  = '0;
        if (d_fire) begin
            mem_en   = 1'b1;
            mem_we   = d_wbe;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end else if (if_fire) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= 4'd0;
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
        end else begin
            if_resp_valid <= if_fire;
            d_resp_valid  <= d_fire;
            if (!if_valid || if_ready) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Read data comes straight from the memory; the resp_valid flags say whose it is.
    assign if_rdata = mem_dout;
    assign d_rdata  = mem_dout;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: table-driven vectors plus hand sequences
// for starvation, reset mid-operation and withdrawn requests, with a response scoreboard.
module tb_imem_dmem_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid, if_ready, if_resp_valid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_valid, d_ready, d_resp_valid;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [3:0]    d_wbe;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din, mem_dout;

    imem_dmem_arbiter #(.AWIDTH(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wbe(d_wbe), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Shared memory model: synchronous read, byte-enabled write.
    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    typedef struct {
        logic          is_data;
        logic          is_write;
        logic [31:0]   data;
    } resp_t;

    resp_t resp_q[$];

    typedef struct {
        logic          iv;
        logic          dv;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [3:0]    wbe;
        logic [31:0]   wd;
        logic          exp_ir;
        logic          exp_dr;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One clock cycle: drive at the falling edge, check just after, predict responses.
    task automatic cycle(input logic r, input logic iv, input logic dv,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [3:0] wbe, input logic [31:0] wd,
                         input logic exp_ir, input logic exp_dr, input string tag);
        resp_t         e;
        logic          has;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        rst = r; if_valid = iv; d_valid = dv; if_addr = ia; d_addr = da;
        d_wbe = wbe; d_wdata = wd;
        #1;
        check({tag, " if_ready"}, 32'(if_ready), 32'(exp_ir));
        check({tag, " d_ready"}, 32'(d_ready), 32'(exp_dr));
        check({tag, " both_ready"}, 32'(if_ready & d_ready), 32'd0);
        exp_addr = exp_dr ? da : (exp_ir ? ia : '0);
        check({tag, " mem_en"}, 32'(mem_en), 32'(exp_ir | exp_dr));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, " mem_we"}, 32'(mem_we), 32'(exp_dr ? wbe : 4'b0000));
        if (exp_dr) check({tag, " mem_din"}, mem_din, wd);

        has = (resp_q.size() > 0);
        if (has) e = resp_q.pop_front();
        check({tag, " if_resp_valid"}, 32'(if_resp_valid), 32'(has && !e.is_data));
        check({tag, " d_resp_valid"}, 32'(d_resp_valid), 32'(has && e.is_data));
        if (has && !e.is_data) check({tag, " if_rdata"}, if_rdata, e.data);
        if (has && e.is_data && !e.is_write) check({tag, " d_rdata"}, d_rdata, e.data);

        if (exp_dr) begin
            e.is_data  = 1'b1;
            e.is_write = (wbe != 4'b0000);
            e.data     = ref_mem[da];
            for (int b = 0; b < 4; b++)
                if (wbe[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
            resp_q.push_back(e);
        end else if (exp_ir) begin
            e.is_data  = 1'b0;
            e.is_write = 1'b0;
            e.data     = ref_mem[ia];
            resp_q.push_back(e);
        end
    endtask

    vec_t vecs[8];

    initial begin
        rst = 1'b1; if_valid = 1'b0; d_valid = 1'b0; if_addr = '0; d_addr = '0;
        d_wbe = 4'b0; d_wdata = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h5A5A_0000 | i;
        mem[12'h010] = 32'h0000_0013;
        mem[12'h020] = 32'hDEAD_BEEF;
        mem[12'h004] = 32'h0010_0093;
        mem[12'h030] = 32'hAAAA_AAAA;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = mem[i];

        //          iv    dv    ia       da       wbe   wd            ir    dr
        vecs[0] = '{1'b1, 1'b0, 12'h010, 12'h000, 4'h0, 32'h0,        1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 12'h004, 12'h020, 4'h0, 32'h0,        1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 12'h004, 12'h000, 4'h0, 32'h0,        1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 12'h000, 12'h030, 4'h3, 32'h12345678, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 12'h000, 12'h030, 4'h0, 32'h0,        1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 32'h0,        1'b0, 1'b0};

        // Reset held with both requesters active: nothing may be granted.
        cycle(1'b1, 1'b1, 1'b1, 12'h001, 12'h002, 4'h0, 32'h0, 1'b0, 1'b0, "reset0");
        cycle(1'b1, 1'b1, 1'b1, 12'h001, 12'h002, 4'h0, 32'h0, 1'b0, 1'b0, "reset1");

        foreach (vecs[i])
            cycle(1'b0, vecs[i].iv, vecs[i].dv, vecs[i].ia, vecs[i].da, vecs[i].wbe,
                  vecs[i].wd, vecs[i].exp_ir, vecs[i].exp_dr, $sformatf("vec%0d", i));

        // Starvation: fetch forced through every fifth cycle.
        for (int c = 0; c < 15; c++)
            cycle(1'b0, 1'b1, 1'b1, 12'h100 + 12'(c), 12'h200 + 12'(c), 4'h0, 32'h0,
                  (c % 5) == 4, (c % 5) != 4, $sformatf("starve%0d", c));

        // Reset asserted at the edge ending a fetch grant: its response is dropped.
        cycle(1'b0, 1'b1, 1'b0, 12'h040, 12'h000, 4'h0, 32'h0, 1'b1, 1'b0, "pre_rst");
        rst = 1'b1;
        resp_q.delete();
        cycle(1'b1, 1'b1, 1'b1, 12'h041, 12'h050, 4'h0, 32'h0, 1'b0, 1'b0, "in_rst0");
        cycle(1'b1, 1'b1, 1'b1, 12'h041, 12'h050, 4'h0, 32'h0, 1'b0, 1'b0, "in_rst1");
        cycle(1'b0, 1'b1, 1'b1, 12'h041, 12'h050, 4'h0, 32'h0, 1'b0, 1'b1, "post_rst");
        cycle(1'b0, 1'b1, 1'b0, 12'h041, 12'h000, 4'h0, 32'h0, 1'b1, 1'b0, "post_rst_f");

        // Fetch denied twice, withdrawn once, then must wait a full MAX_WAIT again.
        cycle(1'b0, 1'b1, 1'b1, 12'h060, 12'h070, 4'h0, 32'h0, 1'b0, 1'b1, "wd_deny0");
        cycle(1'b0, 1'b1, 1'b1, 12'h060, 12'h071, 4'h0, 32'h0, 1'b0, 1'b1, "wd_deny1");
        cycle(1'b0, 1'b0, 1'b1, 12'h060, 12'h072, 4'h0, 32'h0, 1'b0, 1'b1, "wd_drop");
        for (int c = 0; c < 5; c++)
            cycle(1'b0, 1'b1, 1'b1, 12'h061, 12'h080 + 12'(c), 4'h0, 32'h0,
                  c == 4, c != 4, $sformatf("wd_re%0d", c));

        cycle(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 32'h0, 1'b0, 1'b0, "drain");
        check("scoreboard_empty", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read 32-bit memory (BIOS/IMEM) between the Riscv151 instruction-fetch stage and the load/store unit.
- Grants at most one access per cycle. Data accesses have priority. A starvation counter forces a fetch grant after MAX_WAIT cycles of continuous denial.
- Routes each read response back to its requester one cycle after acceptance.

Parameters:
- AWIDTH, 12, word-address width of the shared memory.
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win. Legal range 1..15.

Ports:
- clk  input  1  CPU clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch request present.
- if_ready  output  1  fetch request accepted this cycle (combinational).
- if_addr  input  AWIDTH  fetch word address.
- if_resp_valid  output  1  fetch read data valid.
- if_rdata  output  32  fetch read data.
- d_valid  input  1  data request present.
- d_ready  output  1  data request accepted this cycle (combinational).
- d_addr  input  AWIDTH  data word address.
- d_wdata  input  32  store data.
- d_wbe  input  4  byte write enables; 0 = read.
- d_resp_valid  output  1  data response valid (read data or write ack).
- d_rdata  output  32  data read data.
- mem_en  output  1  memory enable.
- mem_we  output  4  memory byte write enables.
- mem_addr  output  AWIDTH  memory address.
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data, valid the cycle after mem_en.

Behaviour:
- starve = (wait_cnt == MAX_WAIT).
- d_ready = d_valid & ~(if_valid & starve).
- if_ready = if_valid & (~d_valid | starve).
- A transfer fires on valid & ready. The two ready signals are never both 1.
- Memory port:
  - Data grant: mem_en=1, mem_addr=d_addr, mem_we=d_wbe, mem_din=d_wdata.
  - Fetch grant: mem_en=1, mem_addr=if_addr, mem_we=0.
  - No grant: mem_en=0, mem_we=0; mem_addr/mem_din don't-care (drive 0).
- wait_cnt (4-bit, saturating):
  - Next = 0 if ~if_valid or if_ready.
  - Else next = min(wait_cnt+1, MAX_WAIT).
- Response registers:
  - if_resp_valid <= fetch fired; d_resp_valid <= data fired. Exactly one cycle latency.
  - if_rdata and d_rdata = mem_dout, qualified only by their resp_valid.
  - For a write, d_resp_valid pulses as an ack; d_rdata is don't-care.
- Back-to-back: a new grant may fire in the same cycle a response is returned. Full throughput is 1 access per cycle.
- Starvation: with d_valid held high and if_valid held high, the pattern is MAX_WAIT data grants, then 1 fetch grant, repeating.
- Requester drops valid before being granted: no access occurs; wait_cnt clears.
- Reset: on the clock edge with rst=1, wait_cnt=0, if_resp_valid=0, d_resp_valid=0.
  - Any response owed for a grant in the cycle before reset is dropped.
  - While rst=1, if_ready=0, d_ready=0, mem_en=0, mem_we=0.
  - First grant possible in the first cycle with rst=0.

Test Plan:
- Fetch only: if_valid=1, if_addr=0x010, memory word 0x010=0x00000013.
  - Expect if_ready=1 and mem_addr=0x010 in the same cycle.
  - Next cycle: if_resp_valid=1, if_rdata=0x00000013; d_resp_valid stays 0.
- Simultaneous single requests: if_valid=d_valid=1, d_addr=0x020 (word=0xDEADBEEF), if_addr=0x004.
  - Cycle 0: d_ready=1, if_ready=0.
  - Cycle 1: d_rdata=0xDEADBEEF with d_resp_valid=1; fetch granted.
  - Cycle 2: if_resp_valid=1.
- Store then load: d_wbe=4'b0011, d_wdata=0x12345678 to 0x030 (old word 0xAAAAAAAA), then a read of 0x030.
  - Write ack next cycle.
  - Read returns 0xAAAA5678.
- Starvation, MAX_WAIT=4: d_valid and if_valid held high for 15 cycles.
  - Expect fetch grants exactly in cycles 4, 9, 14; data grants in all other cycles.
  - No cycle has both ready signals high.
- Reset mid-operation: fetch granted in cycle N; rst=1 at the edge ending cycle N.
  - if_resp_valid=0 throughout reset.
  - No ready or mem_en while rst=1.
  - A normal grant occurs in the first cycle after rst falls.
- Valid withdrawn: if_valid high for 2 denied cycles, then low for 1 cycle, then high again.
  - wait_cnt returns to 0.
  - Forced fetch grant comes MAX_WAIT cycles after re-assertion, not earlier.
